div_mod_unit: RTL and testbench
===============================

# div_mod_unit

Parametrised multi-cycle integer divider producing quotient and remainder together, signed or unsigned per operation. It sits beside the ALU as the next-generation mod unit and is driven by the datapath through a start/busy/done handshake. Restoring division handles one bit per cycle, with an early-start iteration count taken from the dividend's bit length and single-cycle fast paths for trivial cases. Divide-by-zero and signed-overflow results are defined and flagged.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 4).
- clock  input  1  rising-edge clock, single domain.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clock.
- start  input  1  request; accepted only when busy is low.
- is_signed  input  1  sampled with start; 1 = two's-complement operation, 0 = unsigned.
- a_in  input  WIDTH  dividend; sampled with start.
- b_in  input  WIDTH  divisor; sampled with start.
- quotient  output  WIDTH  registered result; held until the next accepted start.
- remainder  output  WIDTH  registered result; held until the next accepted start.
- busy  output  1  high from the edge after acceptance through the DONE cycle.
- done  output  1  one-cycle pulse marking quotient/remainder valid.
- div_zero  output  1  set with done when b == 0; held with results.
- overflow  output  1  set with done for signed MIN / -1; held with results.

## Operation
- States: IDLE, CHECK, RUN, FIX, DONE. busy = (state != IDLE).
- IDLE, start = 1:
  - Register sa = is_signed & a_in[MSB] and sb = is_signed & b_in[MSB].
  - Register magnitudes |a| and |b| as unsigned WIDTH values; |MIN| = 2^(WIDTH-1) fits.
  - Register n = bit length of |a| (0..WIDTH) and raw a_in.
  - Go to CHECK.
- CHECK:
  - b == 0: q = all ones, r = raw a_in, div_zero = 1; go to FIX with sign fix bypassed.
  - Else |a| < |b| (includes a == 0): q = 0, r = |a|; go to FIX.
  - Else: clear the partial remainder P (WIDTH+1 bits), align |a| so its bit n-1 is at the MSB, load counter = n; go to RUN.
- RUN, per cycle:
  - P = (P << 1) | next dividend bit.
  - T = P − |b| in WIDTH+1 bits.
  - If T[WIDTH] = 0, then P = T and the quotient bit is 1; else the quotient bit is 0.
  - counter−−. Leave for FIX on the cycle counter reaches 0 (exactly n RUN cycles).
- FIX:
  - Quotient negated iff sa ^ sb.
  - Remainder negated iff sa (truncating semantics; remainder takes the dividend's sign).
  - overflow = is_signed & a == MIN & b == all ones; quotient wraps to MIN and remainder is 0.
  - Outputs and flags are registered; go to DONE.
- DONE: done = 1 for this cycle only; go to IDLE.
- start while busy is ignored, with no queueing. start in the DONE cycle is also ignored.
- is_signed = 0: sa = sb = 0, no negation, overflow never set.

## Timing
- Reset (reset = 0 at an edge): state IDLE, and quotient = 0, remainder = 0, busy = 0, done = 0, div_zero = 0, overflow = 0.
- Reset mid-operation aborts the operation immediately with no done pulse.
- Latency is counted from the edge sampling start to the edge raising done:
  - Full path: L = n + 3.
  - Fast path (b == 0 or |a| < |b|): L = 3.
- busy rises on the edge that accepts start and falls on the edge leaving DONE.
- The earliest next acceptance is the edge after that one.
- quotient, remainder and flags change only on the edge entering DONE. They stay stable otherwise, including through the next operation until its DONE.
- done is never high for two consecutive cycles.

## Test plan
- Unsigned 100 / 7 (n = 7) -> quotient 14, remainder 2, done 10 edges after start, flags 0.
- Signed −7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 -> quotient 0xFFFFFFFD, remainder 1.
- 123 / 0 (either mode) -> quotient 0xFFFFFFFF, remainder 123, div_zero 1, latency 3.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow 1. The same operands unsigned -> quotient 0, remainder 0x80000000, overflow 0.
- Unsigned 5 / 9 -> quotient 0, remainder 5, latency 3. Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0, latency 35.
- A second start mid-RUN is ignored and the first result is unchanged. reset = 0 mid-RUN -> all outputs 0, no done pulse. A new start after reset completes correctly.

Source files
------------

// File: rtl/div_mod_unit_if.sv
// rtl/div_mod_unit_if.sv - start/busy/done handshake bundle for div_mod_unit
interface div_mod_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             overflow;

  modport master (
    output start, is_signed, a_in, b_in,
    input  quotient, remainder, busy, done, div_zero, overflow
  );

  modport slave (
    input  start, is_signed, a_in, b_in,
    output quotient, remainder, busy, done, div_zero, overflow
  );
endinterface

// File: rtl/div_mod_unit.sv
// rtl/div_mod_unit.sv - multi-cycle restoring divider producing quotient and remainder
module div_mod_unit #(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  div_mod_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, CHECK, RUN, FIX, DONE} state_t;
  state_t state, state_nxt;

  // Operation context captured at acceptance
  logic             sa, sb, bypass;
  logic [WIDTH-1:0] abs_a, abs_b, raw_a;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] q_work, p_work;
  logic [CW-1:0]    cnt;

  logic             sa_in, sb_in;
  logic [WIDTH-1:0] abs_a_in, abs_b_in;
  logic [CW-1:0]    len_in;

  // Sign bits, magnitudes and dividend bit length of the incoming operands
  always_comb begin
    sa_in    = bus.is_signed & bus.a_in[WIDTH-1];
    sb_in    = bus.is_signed & bus.b_in[WIDTH-1];
    abs_a_in = sa_in ? -bus.a_in : bus.a_in;
    abs_b_in = sb_in ? -bus.b_in : bus.b_in;
    len_in   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (abs_a_in[i]) len_in = CW'(i + 1);
    end
  end

  logic fast_zero, fast_small;
  assign fast_zero  = (abs_b == '0);
  assign fast_small = (abs_a < abs_b);

  // One restoring step: shift in the next dividend bit and trial-subtract.
  // P stays below |b| between steps, so WIDTH bits hold it and p_shift[WIDTH]
  // can only be set when the trial subtraction is guaranteed to succeed.
  logic [WIDTH:0] p_shift, trial;
  assign p_shift = {p_work, dvd[WIDTH-1]};
  assign trial   = p_shift - {1'b0, abs_b};

  logic [WIDTH-1:0] q_fix, r_fix;
  logic             ovf_fix;

  // Sign correction of the magnitude result; divide-by-zero results pass through raw
  always_comb begin
    ovf_fix = sa & sb & (abs_a == MIN_VAL) & (abs_b == ONE_VAL);
    q_fix   = q_work;
    r_fix   = p_work;
    if (!bypass) begin
      if (ovf_fix) begin
        q_fix = MIN_VAL;
        r_fix = '0;
      end else begin
        if (sa ^ sb) q_fix = -q_work;
        if (sa)      r_fix = -p_work;
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nxt = state;
    bus.busy  = (state != IDLE);
    bus.done  = (state == DONE);
    case (state)
      IDLE:    if (bus.start) state_nxt = CHECK;
      CHECK:   state_nxt = (fast_zero || fast_small) ? FIX : RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, fast paths, iteration and result registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      sa            <= 1'b0;
      sb            <= 1'b0;
      bypass        <= 1'b0;
      abs_a         <= '0;
      abs_b         <= '0;
      raw_a         <= '0;
      dvd           <= '0;
      q_work        <= '0;
      p_work        <= '0;
      cnt           <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa    <= sa_in;
            sb    <= sb_in;
            abs_a <= abs_a_in;
            abs_b <= abs_b_in;
            raw_a <= bus.a_in;
            cnt   <= len_in;
          end
        end
        CHECK: begin
          if (fast_zero) begin
            q_work <= '1;
            p_work <= raw_a;
            bypass <= 1'b1;
          end else if (fast_small) begin
            q_work <= '0;
            p_work <= abs_a;
            bypass <= 1'b0;
          end else begin
            q_work <= '0;
            p_work <= '0;
            bypass <= 1'b0;
            // Skip leading zeros: the top set bit of |a| enters first
            dvd    <= abs_a << (CW'(WIDTH) - cnt);
          end
        end
        RUN: begin
          p_work <= trial[WIDTH] ? p_shift[WIDTH-1:0] : trial[WIDTH-1:0];
          q_work <= {q_work[WIDTH-2:0], ~trial[WIDTH]};
          dvd    <= dvd << 1;
          cnt    <= cnt - 1'b1;
        end
        FIX: begin
          bus.quotient  <= q_fix;
          bus.remainder <= r_fix;
          bus.div_zero  <= bypass;
          bus.overflow  <= ovf_fix;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_mod_unit.sv
// tb/tb_div_mod_unit.sv - randomized self-checking bench for div_mod_unit
module tb_div_mod_unit;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;

  div_mod_unit_if #(.WIDTH(W)) bus ();
  div_mod_unit #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the result and latency must be, from plain integer arithmetic
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov, output int lat);
    logic [W-1:0] ma, mb, x;
    int n;
    ma = (s && a[W-1]) ? (32'd0 - a) : a;
    mb = (s && b[W-1]) ? (32'd0 - b) : b;
    n = 0;
    x = ma;
    while (x != 0) begin
      n++;
      x = x >> 1;
    end
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b;
    end else if (a == MIN && b == '1) begin
      q = MIN; r = '0; ov = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    lat = (b == 0 || ma < mb) ? 3 : n + 3;
  endfunction

  // Model state, advanced on every rising edge
  int           cyc = 0;
  int           exp_done_cyc = 0;
  logic         pending = 1'b0;
  logic         model_on = 1'b0;
  logic         acc;
  logic [W-1:0] exp_q, exp_r, held_q = '0, held_r = '0;
  logic         exp_dz, exp_ov, held_dz = 1'b0, held_ov = 1'b0;
  int           m_lat;
  logic         exp_done_now;

  initial forever begin
    @(posedge clock);
    cyc++;
    if (!reset) begin
      pending  = 1'b0;
      held_q   = '0;
      held_r   = '0;
      held_dz  = 1'b0;
      held_ov  = 1'b0;
      model_on = 1'b1;
    end else begin
      acc = bus.start && !pending;
      if (pending && cyc == exp_done_cyc + 1) pending = 1'b0;
      if (acc) begin
        model(bus.a_in, bus.b_in, bus.is_signed, exp_q, exp_r, exp_dz, exp_ov, m_lat);
        exp_done_cyc = cyc + m_lat - 1;
        pending = 1'b1;
      end
    end
  end

  // Compare process: every cycle after reset, away from the active edge
  initial forever begin
    @(negedge clock);
    if (model_on) begin
      exp_done_now = pending && (cyc == exp_done_cyc);
      if (exp_done_now) begin
        held_q  = exp_q;
        held_r  = exp_r;
        held_dz = exp_dz;
        held_ov = exp_ov;
      end
      check("busy", bus.busy, pending);
      check("done", bus.done, exp_done_now);
      check("quotient", bus.quotient, held_q);
      check("remainder", bus.remainder, held_r);
      check("div_zero", bus.div_zero, held_dz);
      check("overflow", bus.overflow, held_ov);
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int lat);
    @(negedge clock);
    bus.a_in = a; bus.b_in = b; bus.is_signed = s; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    check("done_seen", bus.done, 1'b1);
  endtask

  // Hand-computed expectations pinning both the model and the DUT
  task automatic dir(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                     input logic eov, input int elat);
    logic [W-1:0] mq, mr;
    logic mdz, mov;
    int ml, lat;
    model(a, b, s, mq, mr, mdz, mov, ml);
    check({name, "_model_q"}, mq, eq);
    check({name, "_model_r"}, mr, er);
    check({name, "_model_lat"}, ml, elat);
    run_op(a, b, s, lat);
    check({name, "_q"}, bus.quotient, eq);
    check({name, "_r"}, bus.remainder, er);
    check({name, "_dz"}, bus.div_zero, edz);
    check({name, "_ov"}, bus.overflow, eov);
    check({name, "_lat"}, lat, elat);
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = '0;
      1:       v = '1;
      2:       v = MIN;
      3:       v = 32'd1;
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    if ($urandom_range(0, 3) == 0) v = 32'd0 - v;
    return v;
  endfunction

  int   lat, k, ndone;
  logic saw_done;

  initial begin
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (2) @(negedge clock);
    check("rst_q", bus.quotient, 0);
    check("rst_r", bus.remainder, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz", bus.div_zero, 0);
    check("rst_ov", bus.overflow, 0);
    reset = 1'b1;

    dir("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 10);
    dir("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 6);
    dir("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 6);
    dir("u123_0", 32'd123, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd123, 1'b1, 1'b0, 3);
    dir("s123_0", 32'd123, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd123, 1'b1, 1'b0, 3);
    dir("s_ovf", MIN, 32'hFFFF_FFFF, 1'b1, MIN, 32'd0, 1'b0, 1'b1, 35);
    dir("u_ovf_ops", MIN, 32'hFFFF_FFFF, 1'b0, 32'd0, MIN, 1'b0, 1'b0, 3);
    dir("u5_9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 1'b0, 3);
    dir("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 35);
    dir("u0_5", 32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3);
    dir("smin_1", MIN, 32'd1, 1'b1, MIN, 32'd0, 1'b0, 1'b0, 35);

    // Second start mid-RUN is ignored
    @(negedge clock);
    bus.a_in = 32'd100; bus.b_in = 32'd7; bus.is_signed = 1'b0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    bus.a_in = 32'd5; bus.b_in = 32'd9; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("ignore_done_seen", bus.done, 1'b1);
    check("ignore_q", bus.quotient, 32'd14);
    check("ignore_r", bus.remainder, 32'd2);

    // Reset mid-RUN aborts without a done pulse
    @(negedge clock);
    bus.a_in = 32'hFFFF_FFFF; bus.b_in = 32'd1; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort_q", bus.quotient, 0);
    check("abort_r", bus.remainder, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 1'b0);
    dir("after_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 10);

    // start held high: DONE-cycle start ignored, next accepted one edge later
    @(negedge clock);
    bus.a_in = 32'd7; bus.b_in = 32'd2; bus.is_signed = 1'b0; bus.start = 1'b1;
    ndone = 0;
    repeat (18) begin
      @(negedge clock);
      if (bus.done) ndone++;
    end
    bus.start = 1'b0;
    check("held_start_dones", ndone, 2);
    k = 0;
    while (bus.busy && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("held_start_idle", bus.busy, 1'b0);

    // Randomized operations, checked cycle by cycle by the compare process
    for (int i = 0; i < 300; i++) begin
      run_op(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), lat);
    end

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
